// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the synchronous FIFO controller.
package sync_fifo_pkg;

  // Pointers carry one bit beyond the storage address to tell full from empty.
  localparam int unsigned PtrExtraBits        = 1;
  localparam int unsigned DefAddrWidth        = 4;
  localparam int unsigned DefDataWidth        = 16;
  localparam int unsigned DefAlmostFullMargin = 2;
  localparam int unsigned DefAlmostEmptyNum   = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_sdpram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous (combinational) read.
module fifo_sdpram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(AddrWidth);

  // No reset: contents are meaningless until written, which keeps this mappable to LUT RAM.
  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointer/count bookkeeping, registered flags and read register
// around a distributed RAM.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DefAddrWidth,
  parameter int unsigned DATA_WIDTH       = DefDataWidth,
  parameter int unsigned ALMOST_FULL_NUM  = fifo_depth(ADDR_WIDTH) - DefAlmostFullMargin,
  parameter int unsigned ALMOST_EMPTY_NUM = DefAlmostEmptyNum
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + PtrExtraBits;
  localparam int unsigned Depth    = fifo_depth(ADDR_WIDTH);
  localparam logic [PtrWidth-1:0] DepthCount = PtrWidth'(Depth);

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  fifo_sdpram #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_ram (
    .clk_i  (wr_clk),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(ram_rdata)
  );

  // Acceptance is judged on the registered flags, so a same-cycle read never frees a full slot.
  always_comb begin
    wr_ok          = wr_en & ~full_q;
    rd_ok          = rd_en & ~empty_q;
    wr_ptr_d       = wr_ptr_q + PtrWidth'(wr_ok);
    rd_ptr_d       = rd_ptr_q + PtrWidth'(rd_ok);
    count_d        = wr_ptr_d - rd_ptr_d;
    full_d         = (count_d == DepthCount);
    empty_d        = (count_d == '0);
    almost_full_d  = (32'(count_d) >= ALMOST_FULL_NUM);
    almost_empty_d = (32'(count_d) <= ALMOST_EMPTY_NUM);
    wr_err_d       = wr_en & full_q;
    rd_err_d       = rd_en & empty_q;
    rd_data_d      = rd_ok ? ram_rdata : rd_data_q;
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      wr_err_q       <= 1'b0;
      rd_err_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      wr_err_q       <= wr_err_d;
      rd_err_q       <= rd_err_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign full           = full_q;
  assign almost_full    = almost_full_q;
  assign empty          = empty_q;
  assign almost_empty   = almost_empty_q;
  assign wr_water_level = count_q;
  assign wr_err         = wr_err_q;
  assign rd_err         = rd_err_q;

endmodule
